// File: rtl/addsub_seq_pkg.sv
// addsub_seq_pkg: shared FSM state enum and slice width for addsub_seq
package addsub_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SLICE = 4;
endpackage

// File: rtl/CLA_4bit.sv
// CLA_4bit: 4-bit carry-lookahead slice; a,b,cin in -> s, cout, ovfl (carry into msb xor carry out)
module CLA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       ovfl
);
  logic [3:0] g, p;
  logic c1, c2, c3, c4;
  assign g = a & b;
  assign p = a ^ b;
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
  assign s = p ^ {c3, c2, c1, cin};
  assign cout = c4;
  assign ovfl = c4 ^ c3;
endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: nibble-serial add/sub with saturation; in_valid/in_ready request, out_valid/out_ready result, sum/cout/ovfl/zero, busy
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLICE*NIBBLES-1:0]   a,
  input  logic [SLICE*NIBBLES-1:0]   b,
  input  logic                       sub,
  input  logic                       sat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE*NIBBLES-1:0]   sum,
  output logic                       cout,
  output logic                       ovfl,
  output logic                       zero,
  output logic                       busy
);
  localparam int W = SLICE * NIBBLES;
  localparam int KW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] KL = KW'(NIBBLES - 1);
  state_t state, nstate;
  logic [KW-1:0] k;
  logic [W-1:0] ra, rb, result, nxt, fin;
  logic rsat, carry, cout_r, ovfl_r, zero_r;
  logic [SLICE-1:0] ss;
  logic sc, sv, last, acc;
  CLA_4bit u_cla (
    .a(ra[SLICE*k +: SLICE]),
    .b(rb[SLICE*k +: SLICE]),
    .cin(carry),
    .s(ss),
    .cout(sc),
    .ovfl(sv)
  );
  assign last = k == KL;
  assign acc = in_valid && in_ready && !flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  always_comb
    nstate = flush ? IDLE
           : (state == IDLE && in_valid) ? RUN
           : (state == RUN && last) ? DONE
           : (state == DONE && out_ready) ? IDLE
           : state;
  always_comb begin
    in_ready = state == IDLE;
    busy = state == RUN;
    out_valid = state == DONE;
  end
  always_comb begin
    nxt = result;
    nxt[SLICE*k +: SLICE] = ss;
    fin = (last && rsat && sv) ? {ra[W-1], {(W-1){~ra[W-1]}}} : nxt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      rsat <= 1'b0;
      carry <= 1'b0;
      k <= '0;
      result <= '0;
      cout_r <= 1'b0;
      ovfl_r <= 1'b0;
      zero_r <= 1'b0;
    end else if (acc) begin
      ra <= a;
      rb <= sub ? ~b : b;
      rsat <= sat;
      carry <= sub;
      k <= '0;
    end else if (busy && !flush) begin
      result <= fin;
      carry <= sc;
      k <= last ? '0 : k + 1'b1;
      if (last) begin
        cout_r <= sc;
        ovfl_r <= sv;
        zero_r <= fin == '0;
      end
    end
  assign sum = result;
  assign cout = cout_r;
  assign ovfl = ovfl_r;
  assign zero = zero_r;
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed self-checking bench for addsub_seq with arithmetic reference model
module tb_addsub_seq;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, sub = 0, sat = 0, out_ready = 0;
  logic in_ready, out_valid, cout, ovfl, zero, busy;
  logic [W-1:0] a = '0, b = '0, sum;
  int compared = 0, mismatched = 0;
  int phase = 0, cnt = 0;
  logic [W+2:0] exp_r = '0;
  always #5 clk = ~clk;
  addsub_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovfl(ovfl), .zero(zero), .busy(busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic st);
    logic [W:0] f;
    logic [W-1:0] r;
    logic v;
    f = {1'b0, x} + {1'b0, s ? ~y : y} + (W+1)'(s);
    r = f[W-1:0];
    v = (s ? x[W-1] != y[W-1] : x[W-1] == y[W-1]) && r[W-1] != x[W-1];
    if (st && v) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return {r, f[W], v, r == '0};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) phase = 0;
    else if (flush) phase = 0;
    else if (phase == 0 && in_valid) begin
      phase = 1;
      cnt = N;
      exp_r = model(a, b, sub, sat);
    end else if (phase == 1) begin
      cnt = cnt - 1;
      if (cnt == 0) phase = 2;
    end else if (phase == 2 && out_ready) phase = 0;
  always @(negedge clk)
    if (rst_n) begin
      chk("cyc in_ready", 32'(in_ready), 32'(phase == 0));
      chk("cyc busy", 32'(busy), 32'(phase == 1));
      chk("cyc out_valid", 32'(out_valid), 32'(phase == 2));
      if (phase == 2) begin
        chk("cyc sum", 32'(sum), 32'(exp_r[W+2:3]));
        chk("cyc flags", 32'({cout, ovfl, zero}), 32'(exp_r[2:0]));
      end
    end
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic st,
                    input logic [W-1:0] es, input logic [2:0] ef, input int hold);
    logic [W+2:0] m;
    int n;
    m = model(x, y, s, st);
    chk("model sum", 32'(m[W+2:3]), 32'(es));
    chk("model flags", 32'(m[2:0]), 32'(ef));
    @(negedge clk); #1;
    a = x; b = y; sub = s; sat = st; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) out_ready = 0;
    end
    chk("latency", 32'(n), 32'(N));
    chk("sum", 32'(sum), 32'(es));
    chk("flags", 32'({cout, ovfl, zero}), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; a = ~x; b = ~y;
      @(posedge clk); #1;
      chk("hold sum", 32'(sum), 32'(es));
      chk("hold flags", 32'({cout, ovfl, zero}), 32'(ef));
      chk("hold in_ready", 32'(in_ready), 32'(0));
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("released", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    chk("not queued", 32'(busy), 32'(0));
  endtask
  initial begin
    #1;
    chk("rst in_ready", 32'(in_ready), 32'(1));
    chk("rst out_valid", 32'(out_valid), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst sum", 32'(sum), 32'(0));
    chk("rst flags", 32'({cout, ovfl, zero}), 32'(0));
    #11 rst_n = 1;
    op(16'h1234, 16'h4321, 0, 0, 16'h5555, 3'b000, 0);
    op(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 3'b010, 0);
    op(16'h7FFF, 16'h0001, 0, 1, 16'h7FFF, 3'b010, 0);
    op(16'h0005, 16'h0005, 1, 0, 16'h0000, 3'b101, 0);
    op(16'h8000, 16'h0001, 1, 1, 16'h8000, 3'b110, 0);
    op(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 3'b101, 0);
    op(16'h1234, 16'h4321, 0, 0, 16'h5555, 3'b000, 10);
    @(negedge clk); #1;
    a = 16'h1111; b = 16'h2222; sub = 0; sat = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort in_ready", 32'(in_ready), 32'(1));
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort out_valid", 32'(out_valid), 32'(0));
    chk("abort sum", 32'(sum), 32'(0));
    chk("abort flags", 32'({cout, ovfl, zero}), 32'(0));
    @(negedge clk); #1 rst_n = 1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("after rst no out", 32'(out_valid), 32'(0));
    end
    a = 16'h1111; b = 16'h2222; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush idle", 32'(in_ready), 32'(1));
    repeat (6) begin
      @(posedge clk); #1;
      chk("flush no out", 32'(out_valid), 32'(0));
    end
    in_valid = 1; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    chk("flush beats accept", 32'(busy), 32'(0));
    op(16'h0F0F, 16'h0101, 1, 0, 16'h0E0E, 3'b100, 2);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit slices (operand width W = 4*NIBBLES).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port flush, input, 1, synchronous abort of any operation in progress.
REQ-005 The block SHALL have port in_valid, input, 1, meaning a request is presented.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block can accept a request.
REQ-007 The block SHALL have ports a and b, input, W each, the operands, two's complement.
REQ-008 The block SHALL have port sub, input, 1; 1 selects a-b, 0 selects a+b.
REQ-009 The block SHALL have port sat, input, 1; 1 selects signed saturation on overflow.
REQ-010 The block SHALL have port out_valid, output, 1, meaning the result is held.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-012 The block SHALL have port sum, output, W, the result.
REQ-013 The block SHALL have ports cout, ovfl and zero, output, 1 each, the carry-out, signed-overflow and result==0 flags.
REQ-014 The block SHALL have port busy, output, 1, high when the FSM is in RUN.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL occur when in_valid and in_ready are both 1; on accept, a, b (inverted when sub=1), sub and sat SHALL be captured, carry SHALL be set to sub, slice index to 0, and the state to RUN.
REQ-017 In RUN, each cycle SHALL feed slice index k (bits 4k+3:4k) of the captured operands plus the carry register to one 4-bit carry-lookahead slice, store the 4-bit sum into result bits 4k+3:4k, register the slice carry-out, and increment k.
REQ-018 On the RUN cycle with k = NIBBLES-1, the block SHALL register cout and ovfl from that slice and transition to DONE; out_valid SHALL therefore rise exactly NIBBLES cycles after the accept edge.
REQ-019 With sat=1 and ovfl=1, sum SHALL be the most positive value (0x7FFF for W=16) if the captured a is non-negative, otherwise the most negative value (0x8000); ovfl SHALL remain 1.
REQ-020 zero SHALL reflect the final sum after saturation.
REQ-021 In DONE, out_valid SHALL be 1 and sum and all flags SHALL be stable until out_ready=1; out_ready=1 SHALL return the state to IDLE on the next edge.
REQ-022 out_ready asserted outside DONE SHALL be ignored, and in_valid outside IDLE SHALL be ignored and not queued.
REQ-023 Back-to-back requests SHALL have a minimum spacing of NIBBLES+2 cycles; no accept SHALL occur in the DONE->IDLE cycle.
REQ-024 flush=1 SHALL force IDLE on the next edge from any state, clearing out_valid and discarding any partial result; flush SHALL take priority over accept and out_ready in the same cycle.
REQ-025 The carry out of W bits SHALL be dropped into cout only; sum SHALL never be wider than W.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, k=0, carry=0, sum=0, cout=ovfl=zero=0, out_valid=0 and busy=0, with in_ready=1 once released; reset mid-RUN SHALL abandon the operation with no output.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE) and the slice width constant 4.
REQ-028 The block SHALL instantiate exactly one existing 4-bit carry-lookahead slice, CLA_4bit, as its only sub-module; no other adder SHALL be inferred.

Verification
REQ-029 Add: accept a=0x1234, b=0x4321, sub=0 -> out_valid 4 cycles later with sum=0x5555, cout=0, ovfl=0, zero=0.
REQ-030 Overflow: 0x7FFF+0x0001, sat=0 -> sum=0x8000, ovfl=1; the same operands with sat=1 -> sum=0x7FFF, ovfl=1.
REQ-031 Subtract: 0x0005-0x0005 -> sum=0x0000, cout=1, zero=1; 0x8000-0x0001 with sat=1 -> sum=0x8000, ovfl=1.
REQ-032 Backpressure: out_ready held 0 for 10 cycles -> sum and flags unchanged and in_ready=0 throughout; on out_ready=1, IDLE on the next edge.
REQ-033 Abort: rst_n pulsed low at k=2 of 0x1111+0x2222 -> immediate IDLE with all outputs 0; flush at k=1 -> IDLE next edge and no out_valid.
